// File: rtl/data_mem_responder_pkg.sv
// ----------------------------------------------------------------------------
// dm_pkg
// Shared definitions for the data-memory responder and the core-side shim:
//   size_e  : load/store access size encoding as carried on req_size
//   state_e : responder FSM state encoding (2 bits)
//   req_s   : request fields captured at accept time
// ----------------------------------------------------------------------------
package dm_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } state_e;

    typedef struct packed {
        logic        write;
        size_e       size;
        logic        is_unsigned;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_s;

endpackage

// File: rtl/data_mem_responder_if.sv
// ----------------------------------------------------------------------------
// data_mem_responder_if
// Load/store port between the core (master) and the data memory (slave).
//   Request  : req_valid/req_ready handshake carrying write, size, unsigned,
//              byte address and right-aligned store data.
//   Response : rsp_valid/rsp_ready handshake carrying extended load data and
//              an error flag.
// ----------------------------------------------------------------------------
interface data_mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/data_mem_responder_lane_align.sv
// ----------------------------------------------------------------------------
// dm_lane_align (combinational)
// Maps an access size and the low address bits onto the four byte lanes of a
// 32-bit word.
//   size, addr_lo, is_unsigned : access description
//   wdata     : right-aligned store data
//   rword     : full storage word read at the access index
//   byte_en   : lanes written by a store
//   wdata_rep : store data replicated across the lanes
//   rdata_ext : load data shifted down and sign/zero extended
//   misalign  : misaligned half/word or illegal size
// ----------------------------------------------------------------------------
module dm_lane_align
    import dm_pkg::*;
(
    input  size_e       size,
    input  logic [1:0]  addr_lo,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  byte_en,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext,
    output logic        misalign
);
    logic [31:0] rshift;

    always_comb begin
        byte_en   = 4'b0000;
        wdata_rep = 32'h0;
        rdata_ext = 32'h0;
        misalign  = 1'b0;
        // Bring the addressed byte/half down to bit 0 before extending.
        rshift    = rword >> {addr_lo, 3'b000};
        case (size)
            SZ_BYTE: begin
                byte_en   = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
                rdata_ext = {{24{~is_unsigned & rshift[7]}}, rshift[7:0]};
            end
            SZ_HALF: begin
                misalign  = addr_lo[0];
                byte_en   = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata[15:0]}};
                rdata_ext = {{16{~is_unsigned & rshift[15]}}, rshift[15:0]};
            end
            SZ_WORD: begin
                misalign  = (addr_lo != 2'b00);
                byte_en   = 4'b1111;
                wdata_rep = wdata;
                rdata_ext = rword;
            end
            default: misalign = 1'b1;
        endcase
    end
endmodule

// File: rtl/data_mem_responder.sv
// ----------------------------------------------------------------------------
// data_mem_responder
// Memory-side responder for the core load/store port. Accepts one request at a
// time, stalls WAIT_STATES cycles, then commits the access (lane-masked store
// or extended load) on the edge entering RESP and holds the response until the
// core takes it.
//   clk  : rising-edge clock
//   rst  : asynchronous reset, active low
//   bus  : slave side of data_mem_responder_if
// Storage contents are not reset.
// ----------------------------------------------------------------------------
module data_mem_responder
    import dm_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_STATES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    data_mem_responder_if.slave  bus
);
    localparam int IDX_W = $clog2(DEPTH_WORDS);

    state_e         state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    req_s           req_q, req_d;
    logic [31:0]    rsp_rdata_q, rsp_rdata_d;
    logic           rsp_err_q, rsp_err_d;

    req_s           acc_req;
    logic           accept;
    logic           commit;
    logic           acc_err;
    logic           out_of_range;
    logic           misalign;
    logic           mem_we;
    logic [IDX_W-1:0] idx;
    logic [3:0]     byte_en;
    logic [31:0]    wdata_rep;
    logic [31:0]    rdata_ext;
    logic [31:0]    rword;

    assign accept = (state_q == ST_IDLE) && bus.req_valid;

    // With zero wait states the access commits on the accept edge itself, so
    // the live bus fields are used in IDLE and the captured copy afterwards.
    always_comb begin
        acc_req = req_q;
        if (state_q == ST_IDLE) begin
            acc_req.write       = bus.req_write;
            acc_req.size        = size_e'(bus.req_size);
            acc_req.is_unsigned = bus.req_unsigned;
            acc_req.addr        = bus.req_addr;
            acc_req.wdata       = bus.req_wdata;
        end
    end

    assign idx          = acc_req.addr[IDX_W+1:2];
    assign out_of_range = |acc_req.addr[31:IDX_W+2];

    dm_lane_align u_lane_align (
        .size        (acc_req.size),
        .addr_lo     (acc_req.addr[1:0]),
        .is_unsigned (acc_req.is_unsigned),
        .wdata       (acc_req.wdata),
        .rword       (rword),
        .byte_en     (byte_en),
        .wdata_rep   (wdata_rep),
        .rdata_ext   (rdata_ext),
        .misalign    (misalign)
    );

    assign acc_err = misalign | out_of_range;
    assign mem_we  = commit & acc_req.write & ~acc_err;

    // Storage split into byte lanes so each lane has a single writer.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH_WORDS];

            always_ff @(posedge clk) begin
                if (mem_we && byte_en[gi]) begin
                    lane_mem[idx] <= wdata_rep[gi*8 +: 8];
                end
            end

            assign rword[gi*8 +: 8] = lane_mem[idx];
        end
    endgenerate

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            req_q       <= '0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_q       <= req_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (WAIT_STATES == 0) begin
                        state_d = ST_RESP;
                        commit  = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = 4'(WAIT_STATES - 1);
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_RESP;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Request capture and response registers
    always_comb begin
        req_d       = accept ? acc_req : req_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        if (commit) begin
            rsp_err_d   = acc_err;
            rsp_rdata_d = (acc_err || acc_req.write) ? 32'h0 : rdata_ext;
        end
    end

    // Output logic
    always_comb begin
        bus.req_ready = (state_q == ST_IDLE);
        bus.rsp_valid = (state_q == ST_RESP);
        bus.rsp_rdata = rsp_rdata_q;
        bus.rsp_err   = rsp_err_q;
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// ----------------------------------------------------------------------------
// tb_data_mem_responder
// Directed bench for data_mem_responder: one instance with two wait states and
// one with none. Expected responses go into a scoreboard queue when a request
// is driven and are popped when the response appears.
// ----------------------------------------------------------------------------
module tb_data_mem_responder;
    import dm_pkg::*;

    localparam int WS_A = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    data_mem_responder_if bus_a ();
    data_mem_responder_if bus_b ();

    data_mem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(WS_A)) u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a.slave)
    );

    data_mem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(0)) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b.slave)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb_q[$];

    // Stream for the zero-wait-state instance
    localparam int NB = 7;
    logic        b_wr   [NB] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [1:0]  b_sz   [NB] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b00, 2'b10};
    logic        b_uns  [NB] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [31:0] b_addr [NB] = '{32'h0, 32'h4, 32'h0, 32'h4, 32'h3, 32'h3, 32'h2};
    logic [31:0] b_wd   [NB] = '{32'hA0A0_A0A0, 32'h0000_0005, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    logic [31:0] b_exp  [NB] = '{32'h0, 32'h0, 32'hA0A0_A0A0, 32'h0000_0005, 32'h0000_00A0, 32'hFFFF_FFA0, 32'h0};
    logic        b_err  [NB] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // One full transaction on instance A; hold = cycles to keep rsp_ready low.
    task automatic txn(input string tag, input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic exp_err, input int hold);
        exp_t e;
        int   lat;
        sb_q.push_back('{rdata: exp_rdata, err: exp_err});
        @(posedge clk); #1;
        bus_a.req_valid    = 1'b1;
        bus_a.req_write    = wr;
        bus_a.req_size     = sz;
        bus_a.req_unsigned = uns;
        bus_a.req_addr     = addr;
        bus_a.req_wdata    = wdata;
        bus_a.rsp_ready    = (hold == 0);
        @(negedge clk);
        chk1({tag, "/req_ready"}, bus_a.req_ready, 1'b1);
        @(posedge clk); #1;
        // Scramble request fields after accept; they must be ignored.
        bus_a.req_valid    = 1'b0;
        bus_a.req_write    = ~wr;
        bus_a.req_size     = 2'b11;
        bus_a.req_unsigned = ~uns;
        bus_a.req_addr     = 32'hFFFF_FFFC;
        bus_a.req_wdata    = 32'h0BAD_0BAD;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus_a.rsp_valid && lat < 40);
        chk32({tag, "/latency"}, 32'(lat), 32'(WS_A + 1));
        e = sb_q.pop_front();
        chk32({tag, "/rdata"}, bus_a.rsp_rdata, e.rdata);
        chk1({tag, "/err"}, bus_a.rsp_err, e.err);
        $display("txn %s wr=%0b size=%0d addr=0x%08h rdata=0x%08h err=%0b lat=%0d",
                 tag, wr, sz, addr, bus_a.rsp_rdata, bus_a.rsp_err, lat);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk1({tag, "/hold_valid"}, bus_a.rsp_valid, 1'b1);
            chk32({tag, "/hold_rdata"}, bus_a.rsp_rdata, e.rdata);
            chk1({tag, "/hold_req_ready"}, bus_a.req_ready, 1'b0);
        end
        if (hold > 0) begin
            @(posedge clk); #1;
            bus_a.rsp_ready = 1'b1;
        end
        @(posedge clk); #1;
        bus_a.rsp_ready = 1'b0;
        @(negedge clk);
        chk1({tag, "/idle_rsp_valid"}, bus_a.rsp_valid, 1'b0);
        chk1({tag, "/idle_req_ready"}, bus_a.req_ready, 1'b1);
    endtask

    initial begin
        int cyc;
        int last_acc;
        int n_acc;
        int n_rsp;
        exp_t e;

        bus_a.req_valid = 1'b0; bus_a.req_write = 1'b0; bus_a.req_size = 2'b00;
        bus_a.req_unsigned = 1'b0; bus_a.req_addr = 32'h0; bus_a.req_wdata = 32'h0;
        bus_a.rsp_ready = 1'b0;
        bus_b.req_valid = 1'b0; bus_b.req_write = 1'b0; bus_b.req_size = 2'b00;
        bus_b.req_unsigned = 1'b0; bus_b.req_addr = 32'h0; bus_b.req_wdata = 32'h0;
        bus_b.rsp_ready = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk1("reset/req_ready", bus_a.req_ready, 1'b1);
        chk1("reset/rsp_valid", bus_a.rsp_valid, 1'b0);
        chk32("reset/rsp_rdata", bus_a.rsp_rdata, 32'h0);
        chk1("reset/rsp_err", bus_a.rsp_err, 1'b0);
        rst = 1'b1;

        // Word store/load and latency
        txn("sw_10",   1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, 32'h0,         1'b0, 0);
        txn("lw_10",   1'b0, 2'b10, 1'b0, 32'h10, 32'h0,         32'hDEAD_BEEF, 1'b0, 0);
        // Byte store, sign/zero extension
        txn("sb_13",   1'b1, 2'b00, 1'b0, 32'h13, 32'h1234_5680, 32'h0,         1'b0, 0);
        txn("lb_13",   1'b0, 2'b00, 1'b0, 32'h13, 32'h0,         32'hFFFF_FF80, 1'b0, 0);
        txn("lbu_13",  1'b0, 2'b00, 1'b1, 32'h13, 32'h0,         32'h0000_0080, 1'b0, 0);
        txn("lw_10b",  1'b0, 2'b10, 1'b0, 32'h10, 32'h0,         32'h80AD_BEEF, 1'b0, 0);
        txn("lh_12",   1'b0, 2'b01, 1'b0, 32'h12, 32'h0,         32'hFFFF_80AD, 1'b0, 0);
        txn("lhu_12",  1'b0, 2'b01, 1'b1, 32'h12, 32'h0,         32'h0000_80AD, 1'b0, 0);
        txn("sh_12",   1'b1, 2'b01, 1'b0, 32'h12, 32'h5A5A_1234, 32'h0,         1'b0, 0);
        txn("lw_10c",  1'b0, 2'b10, 1'b0, 32'h10, 32'h0,         32'h1234_BEEF, 1'b0, 0);
        txn("lb_11",   1'b0, 2'b00, 1'b0, 32'h11, 32'h0,         32'hFFFF_FFBE, 1'b0, 0);
        // Error cases
        txn("lh_11",   1'b0, 2'b01, 1'b0, 32'h11, 32'h0,         32'h0,         1'b1, 0);
        txn("sw_00",   1'b1, 2'b10, 1'b0, 32'h00, 32'hCAFE_F00D, 32'h0,         1'b0, 0);
        txn("sw_402",  1'b1, 2'b10, 1'b0, 32'h402, 32'h1122_3344, 32'h0,        1'b1, 0);
        txn("sw_400",  1'b1, 2'b10, 1'b0, 32'h400, 32'h5566_7788, 32'h0,        1'b1, 0);
        txn("lw_00",   1'b0, 2'b10, 1'b0, 32'h00, 32'h0,         32'hCAFE_F00D, 1'b0, 0);
        txn("ill_ld",  1'b0, 2'b11, 1'b0, 32'h10, 32'h0,         32'h0,         1'b1, 0);
        txn("ill_st",  1'b1, 2'b11, 1'b0, 32'h10, 32'hFFFF_FFFF, 32'h0,         1'b1, 0);
        // Backpressure on the response, also confirms the illegal store wrote nothing
        txn("lw_hold", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0,         32'h1234_BEEF, 1'b0, 5);

        // Reset during WAIT of a store
        txn("sw_20",   1'b1, 2'b10, 1'b0, 32'h20, 32'h1111_1111, 32'h0,         1'b0, 0);
        txn("lw_20",   1'b0, 2'b10, 1'b0, 32'h20, 32'h0,         32'h1111_1111, 1'b0, 0);
        @(posedge clk); #1;
        bus_a.req_valid = 1'b1; bus_a.req_write = 1'b1; bus_a.req_size = 2'b10;
        bus_a.req_unsigned = 1'b0; bus_a.req_addr = 32'h20; bus_a.req_wdata = 32'h1234_5678;
        @(posedge clk); #1;
        bus_a.req_valid = 1'b0;
        @(negedge clk);
        chk1("rst_wait/in_wait", bus_a.req_ready, 1'b0);
        rst = 1'b0;
        #1;
        chk1("rst_wait/req_ready", bus_a.req_ready, 1'b1);
        chk1("rst_wait/rsp_valid", bus_a.rsp_valid, 1'b0);
        chk32("rst_wait/rsp_rdata", bus_a.rsp_rdata, 32'h0);
        chk1("rst_wait/rsp_err", bus_a.rsp_err, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        txn("lw_20b",  1'b0, 2'b10, 1'b0, 32'h20, 32'h0,         32'h1111_1111, 1'b0, 0);

        // Zero wait states, request held valid, response always ready
        @(posedge clk); #1;
        bus_b.rsp_ready    = 1'b1;
        bus_b.req_valid    = 1'b1;
        bus_b.req_write    = b_wr[0];
        bus_b.req_size     = b_sz[0];
        bus_b.req_unsigned = b_uns[0];
        bus_b.req_addr     = b_addr[0];
        bus_b.req_wdata    = b_wd[0];
        cyc = 0; last_acc = -1; n_acc = 0; n_rsp = 0;
        while (n_rsp < NB && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (bus_b.rsp_valid) begin
                e = sb_q.pop_front();
                chk32($sformatf("ws0_%0d/rdata", n_rsp), bus_b.rsp_rdata, e.rdata);
                chk1($sformatf("ws0_%0d/err", n_rsp), bus_b.rsp_err, e.err);
                $display("txn ws0_%0d rdata=0x%08h err=%0b cyc=%0d", n_rsp, bus_b.rsp_rdata, bus_b.rsp_err, cyc);
                n_rsp++;
            end
            if (bus_b.req_valid && bus_b.req_ready) begin
                if (last_acc >= 0) begin
                    chk32($sformatf("ws0_%0d/accept_gap", n_acc), 32'(cyc - last_acc), 32'd2);
                end
                last_acc = cyc;
                sb_q.push_back('{rdata: b_exp[n_acc], err: b_err[n_acc]});
                n_acc++;
                @(posedge clk); #1;
                if (n_acc < NB) begin
                    bus_b.req_write    = b_wr[n_acc];
                    bus_b.req_size     = b_sz[n_acc];
                    bus_b.req_unsigned = b_uns[n_acc];
                    bus_b.req_addr     = b_addr[n_acc];
                    bus_b.req_wdata    = b_wd[n_acc];
                end else begin
                    bus_b.req_valid = 1'b0;
                end
            end
        end
        chk32("ws0/responses", 32'(n_rsp), 32'(NB));
        chk32("ws0/scoreboard_empty", 32'(sb_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
